// File: rtl/unit_rr_sched.sv
// ----------------------------------------------------------------------------
// unit_rr_sched
//   Round-robin scheduler sharing one 1-bit processing unit among N requesters.
//   A winner is picked with rotating priority, its operand bit is driven onto
//   unit_in for HOLD cycles, then unit_out is captured into result and the
//   winner gets a one-cycle done pulse. One bubble cycle (DONE) separates
//   consecutive transactions.
//
// Ports
//   clk       in   1  system clock, rising edge
//   reset     in   1  asynchronous, active-high reset
//   req       in   N  per-requester transaction request
//   req_bit   in   N  per-requester operand bit, sampled at grant
//   unit_out  in   1  output of the shared unit
//   unit_in   out  1  registered drive to the shared unit input
//   grant     out  N  one-hot owner of the unit (registered)
//   done      out  N  one-hot one-cycle result-valid pulse (registered)
//   result    out  1  captured unit_out, held until the next capture
//   busy      out  1  high whenever the FSM is not in IDLE
//
// Handshake: a requester raises req and keeps it high until its done pulse.
// req/req_bit are sampled only on the granting edge; later changes are
// ignored and a started transaction always completes with done (no abort).
// ----------------------------------------------------------------------------
module unit_rr_sched #(
   parameter int N    = 4,
   parameter int HOLD = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic [N-1:0] req_bit,
   input  logic         unit_out,
   output logic         unit_in,
   output logic [N-1:0] grant,
   output logic [N-1:0] done,
   output logic         result,
   output logic         busy
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [PW-1:0] last;   // most recently served requester
   logic [PW-1:0] cur;    // requester owning the current transaction

   // Rotating-priority pick: search last+1, last+2, ... (mod N).
   logic [PW-1:0] sel;
   logic          sel_found;

   always_comb begin
      sel       = '0;
      sel_found = 1'b0;
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (int'(last) + k) % N;
         if (!sel_found && req[idx]) begin
            sel       = PW'(idx);
            sel_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         grant   <= '0;
         done    <= '0;
         unit_in <= 1'b0;
         result  <= 1'b0;
         busy    <= 1'b0;
         cnt     <= '0;
         last    <= PW'(N - 1);
         cur     <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= '0;
               if (sel_found) begin
                  grant   <= N'(1) << sel;
                  unit_in <= req_bit[sel];
                  cnt     <= CW'(HOLD - 1);
                  cur     <= sel;
                  busy    <= 1'b1;
                  state   <= DRIVE;
               end
            end
            DRIVE: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  result <= unit_out;
                  done   <= N'(1) << cur;
                  grant  <= '0;
                  last   <= cur;
                  state  <= DONE;
               end
            end
            DONE: begin
               // Bubble cycle: no grant here, so done and grant never overlap.
               done  <= '0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               grant <= '0;
               done  <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
